// File: rtl/multi_edge_pulse_gen.sv
// multi_edge_pulse_gen
//   Multi-channel level-to-pulse converter for slow external inputs
//   (buttons, switches). Each channel runs a synchronizer chain, a debounce
//   filter, a mode-selectable edge qualifier and a retriggerable pulse
//   stretcher. A shared saturating counter tallies cycles with any event.
//
// Ports:
//   clk_1Mhz     block clock, rising edge
//   reset        synchronous, active-high reset
//   in           raw asynchronous level inputs, one per channel
//   mode         edge select: 00 rising, 01 falling, 10 both, 11 none
//   clear_count  synchronous clear of event_count (wins over increment)
//   level        debounced, synchronized level per channel
//   pulse        per-channel edge pulse, PULSE_LEN cycles wide
//   event_any    one-cycle flag: some channel started/retriggered a pulse
//   event_count  saturating count of event_any cycles
module multi_edge_pulse_gen #(
    parameter int unsigned N_CH            = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PULSE_LEN       = 1
) (
    input  logic            clk_1Mhz,
    input  logic            reset,
    input  logic [N_CH-1:0] in,
    input  logic [1:0]      mode,
    input  logic            clear_count,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] pulse,
    output logic            event_any,
    output logic [7:0]      event_count
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PW = $clog2(PULSE_LEN + 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PCNT_LOAD = PW'(PULSE_LEN);

    // State encoding is {level, dcnt != 0}.
    typedef enum logic [1:0] {
        LOW_STABLE  = 2'b00,
        LOW_ARMING  = 2'b01,
        HIGH_STABLE = 2'b10,
        HIGH_ARMING = 2'b11
    } db_state_t;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_NONE = 2'b11
    } edge_mode_t;

    edge_mode_t      mode_sel;
    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] s;
    db_state_t       st_q   [N_CH];
    db_state_t       st_d   [N_CH];
    logic [DW-1:0]   dcnt_q [N_CH];
    logic [DW-1:0]   dcnt_d [N_CH];
    logic [PW-1:0]   pcnt_q [N_CH];
    logic [PW-1:0]   pcnt_d [N_CH];
    logic [N_CH-1:0] qual;

    assign mode_sel = edge_mode_t'(mode);
    assign s        = sync_q[SYNC_STAGES-1];

    // Plain flop chain, nothing between stages.
    always_ff @(posedge clk_1Mhz) begin
        if (reset) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++)
                sync_q[k] <= '0;
        end else begin
            sync_q[0] <= in;
            for (int unsigned k = 1; k < SYNC_STAGES; k++)
                sync_q[k] <= sync_q[k-1];
        end
    end

    always_ff @(posedge clk_1Mhz) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                st_q[i]   <= LOW_STABLE;
                dcnt_q[i] <= '0;
                pcnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                st_q[i]   <= st_d[i];
                dcnt_q[i] <= dcnt_d[i];
                pcnt_q[i] <= pcnt_d[i];
            end
        end
    end

    // Debounce + edge qualification + pulse stretcher, per channel.
    always_comb begin
        qual = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            st_d[i]   = st_q[i];
            dcnt_d[i] = dcnt_q[i];
            pcnt_d[i] = pcnt_q[i];

            if (s[i] == st_q[i][1]) begin
                // Agreement (or a bounce back) discards any partial count.
                dcnt_d[i] = '0;
                st_d[i]   = st_q[i][1] ? HIGH_STABLE : LOW_STABLE;
            end else if (dcnt_q[i] == DCNT_LAST) begin
                dcnt_d[i] = '0;
                st_d[i]   = st_q[i][1] ? LOW_STABLE : HIGH_STABLE;
                case (mode_sel)
                    EDGE_RISE: qual[i] = ~st_q[i][1];
                    EDGE_FALL: qual[i] = st_q[i][1];
                    EDGE_BOTH: qual[i] = 1'b1;
                    default:   qual[i] = 1'b0;
                endcase
            end else begin
                dcnt_d[i] = dcnt_q[i] + 1'b1;
                st_d[i]   = st_q[i][1] ? HIGH_ARMING : LOW_ARMING;
            end

            // Reload on every qualified edge; width always PULSE_LEN after the last one.
            if (qual[i])
                pcnt_d[i] = PCNT_LOAD;
            else if (pcnt_q[i] != '0)
                pcnt_d[i] = pcnt_q[i] - 1'b1;
        end
    end

    always_comb begin
        level = '0;
        pulse = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            level[i] = st_q[i][1];
            pulse[i] = (pcnt_q[i] != '0);
        end
    end

    always_ff @(posedge clk_1Mhz) begin
        if (reset) begin
            event_any   <= 1'b0;
            event_count <= '0;
        end else begin
            event_any <= |qual;
            if (clear_count)
                event_count <= '0;
            else if ((|qual) && (event_count != 8'hFF))
                event_count <= event_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_multi_edge_pulse_gen.sv
// tb_multi_edge_pulse_gen
//   Drives two instances (PULSE_LEN=1 and PULSE_LEN=3) from shared inputs and
//   compares every cycle against an edge-indexed history model: a channel's
//   level toggles when the last DEBOUNCE_CYCLES synchronized samples since
//   the previous toggle/reset all disagree with it; a pulse is high while
//   fewer than PULSE_LEN edges have passed since the last qualified edge.
module tb_multi_edge_pulse_gen;

    localparam int N = 4;
    localparam int S = 2;
    localparam int D = 4;
    localparam int HM = 8191;

    logic         clk_1Mhz = 1'b0;
    logic         reset;
    logic [N-1:0] in;
    logic [1:0]   mode;
    logic         clear_count;

    logic [N-1:0] level_a, pulse_a, level_b, pulse_b;
    logic         ev_a, ev_b;
    logic [7:0]   cnt_a, cnt_b;

    always #5 clk_1Mhz = ~clk_1Mhz;

    multi_edge_pulse_gen #(.N_CH(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .PULSE_LEN(1)) u_dut (
        .clk_1Mhz(clk_1Mhz), .reset(reset), .in(in), .mode(mode), .clear_count(clear_count),
        .level(level_a), .pulse(pulse_a), .event_any(ev_a), .event_count(cnt_a));

    multi_edge_pulse_gen #(.N_CH(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .PULSE_LEN(3)) u_dut_p3 (
        .clk_1Mhz(clk_1Mhz), .reset(reset), .in(in), .mode(mode), .clear_count(clear_count),
        .level(level_b), .pulse(pulse_b), .event_any(ev_b), .event_count(cnt_b));

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int           t = 0;
    int           rst_edge = -100000;
    bit           armed = 0;
    logic [N-1:0] in_hist [0:HM];
    logic [N-1:0] s_hist  [0:HM];
    logic [N-1:0] m_level;
    int           last_tog [N];
    int           last_q   [N];
    bit           m_ev;
    int           m_cnt;

    task automatic model_edge();
        logic [N-1:0] s_now;
        bit any_q, tog, newl, q;
        t++;
        in_hist[t & HM] = in;
        if (reset) begin
            rst_edge = t;
            armed    = 1;
            m_level  = '0;
            m_ev     = 0;
            m_cnt    = 0;
            s_hist[t & HM] = '0;
            for (int c = 0; c < N; c++) begin
                last_tog[c] = t;
                last_q[c]   = -100000;
            end
            return;
        end
        if (!armed) return;
        for (int c = 0; c < N; c++)
            s_now[c] = (t - S > rst_edge) ? in_hist[(t - S) & HM][c] : 1'b0;
        s_hist[t & HM] = s_now;
        any_q = 0;
        for (int c = 0; c < N; c++) begin
            tog = (t - (D - 1) > last_tog[c]);
            for (int j = 0; j < D; j++)
                if (s_hist[(t - j) & HM][c] == m_level[c]) tog = 0;
            if (tog) begin
                newl = ~m_level[c];
                q = (mode == 2'b10) || (mode == 2'b00 && newl) || (mode == 2'b01 && !newl);
                m_level[c]  = newl;
                last_tog[c] = t;
                if (q) begin
                    last_q[c] = t;
                    any_q = 1;
                end
            end
        end
        m_ev = any_q;
        if (clear_count) m_cnt = 0;
        else if (any_q && m_cnt < 255) m_cnt++;
    endtask

    task automatic compare_all();
        logic [N-1:0] ep_a, ep_b;
        for (int c = 0; c < N; c++) begin
            ep_a[c] = (t - last_q[c]) < 1;
            ep_b[c] = (t - last_q[c]) < 3;
        end
        check_val("level_p1", level_a, m_level);
        check_val("level_p3", level_b, m_level);
        check_val("pulse_p1", pulse_a, ep_a);
        check_val("pulse_p3", pulse_b, ep_b);
        check_val("event_any_p1", ev_a, m_ev);
        check_val("event_any_p3", ev_b, m_ev);
        check_val("count_p1", cnt_a, m_cnt);
        check_val("count_p3", cnt_b, m_cnt);
    endtask

    task automatic tick();
        @(posedge clk_1Mhz);
        model_edge();
        #1;
        if (armed) compare_all();
    endtask

    int npulse;
    int c0;

    initial begin
        reset = 1'b1; in = '0; mode = 2'b00; clear_count = 1'b0;
        tick(); tick();
        check_val("rst_level", level_a, 0);
        check_val("rst_pulse", pulse_b, 0);
        check_val("rst_count", cnt_a, 0);
        reset = 1'b0;

        // Single rising edge, default latency
        in[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 5) check_val("lat_level_early", level_a[0], 0);
            if (k == 6) begin
                check_val("lat_level", level_a[0], 1);
                check_val("lat_pulse", pulse_a[0], 1);
            end
            if (k == 7) check_val("lat_pulse_end", pulse_a[0], 0);
        end
        check_val("lat_count", cnt_a, 1);
        check_val("lat_others", level_a[3:1], 0);

        // Bounce on channel 1
        npulse = 0;
        for (int k = 0; k < 18; k++) begin
            in[1] = (k < 2 || k >= 4);
            tick();
            npulse += pulse_a[1];
        end
        check_val("bounce_pulses", npulse, 1);

        // Both edges with the stretched instance
        mode = 2'b10; c0 = cnt_b; npulse = 0;
        for (int k = 0; k < 35; k++) begin
            in[2] = (k < 20);
            tick();
            npulse += pulse_b[2];
        end
        check_val("both_pulse_cycles", npulse, 6);
        check_val("both_count", cnt_b, c0 + 2);

        // Disabled mode: level tracks, no events
        mode = 2'b11; c0 = cnt_a;
        for (int k = 0; k < 60; k++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(5) == 0) in[c] = ~in[c];
            tick();
        end
        check_val("off_count", cnt_a, c0);

        // Simultaneous rise on channels 0 and 3
        mode = 2'b00; in = '0;
        for (int k = 0; k < 10; k++) tick();
        c0 = cnt_a;
        in = 4'b1001;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) check_val("simul_pulse", pulse_a, 4'b1001);
        end
        check_val("simul_count", cnt_a, c0 + 1);

        // Saturation
        mode = 2'b10;
        for (int e = 0; e < 300; e++) begin
            in[0] = ~in[0];
            for (int k = 0; k < 6; k++) tick();
        end
        check_val("sat_count", cnt_a, 255);

        // Clear during an event
        in[0] = ~in[0]; clear_count = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        clear_count = 1'b0;
        check_val("clear_count", cnt_a, 0);

        // Reset mid-pulse and mid-debounce, input held high across reset
        in = '0;
        for (int k = 0; k < 10; k++) tick();
        in[1] = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        in[2] = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        reset = 1'b1;
        tick();
        check_val("midrst_level", level_b, 0);
        check_val("midrst_pulse", pulse_b, 0);
        check_val("midrst_event", ev_b, 0);
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 5) check_val("post_rst_early", pulse_a[1], 0);
            if (k == 6) check_val("post_rst_pulse", pulse_a[1], 1);
        end

        // Randomized traffic
        for (int k = 0; k < 800; k++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(7) == 0) in[c] = ~in[c];
            if ($urandom_range(39) == 0) mode = 2'($urandom_range(3));
            clear_count = ($urandom_range(99) == 0);
            reset = ($urandom_range(299) == 0);
            tick();
        end
        reset = 1'b0; clear_count = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
